terrain_compositor: RTL and testbench
=====================================

// Module: terrain_compositor
// PURPOSE
//  Table-driven terrain layer for one playfield: up to NUM_RECTS rectangles with sprite-sheet offsets replace fixed per-map terrain instances.
//  Two-stage pixel pipeline turns (vga_h,vga_v) into a sprite ROM address.
//  Per-frame scanner FSM checks both player boxes against every rectangle, then raises solid/dead/clear flags for game control.
// PARAMETERS
//  NUM_RECTS     8      descriptor table depth (2..16)
//  COORD_W       10     coordinate/size width
//  ADDR_W        17     sprite ROM address width
//  MEM_W         320    sprite sheet row pitch (pixels)
//  DEFAULT_ADDR  12900  address driven when no rectangle covers the pixel
//  PW / PH       10/10  player box width/height
// PORTS
//  clk          in   1         system clock
//  rst          in   1         asynchronous, active-low reset
//  cfg_we       in   1         descriptor write strobe
//  cfg_idx      in   4         descriptor index (>=NUM_RECTS ignored)
//  cfg_data     in   6*COORD_W+3  {valid,type[1:0],ph,pv,w,h,mh,mv}
//  cfg_ready    out  1         table writable (low while scanning)
//  vga_h/vga_v  in   COORD_W   current pixel (scaled playfield coords)
//  addr         out  ADDR_W    sprite ROM address, 2-cycle latency
//  hit          out  1         pixel covered by a rectangle, aligned with addr
//  frame_start  in   1         one-cycle strobe; starts a collision scan
//  p1_h/p1_v, p2_h/p2_v in COORD_W  player top-left corners
//  p1_solid/p2_solid out 1     player overlaps a type-0 rectangle
//  p1_dead/p2_dead   out 1     player overlapped a lethal hazard (sticky)
//  clear        out  1         both players on a goal rectangle (sticky)
//  scan_overrun out  1         frame_start arrived mid-scan (sticky)
// BEHAVIOUR
//  Reset: table valid bits=0, FSM IDLE, addr=DEFAULT_ADDR, hit=0, all flags=0, cfg_ready=1.
//  Types: 0 solid, 1 red hazard (kills p2), 2 blue hazard (kills p1), 3 goal.
//  Table write: cfg_we && cfg_ready && cfg_idx<NUM_RECTS -> entry updated next edge; other writes dropped.
//    Any accepted write clears p1_dead, p2_dead, clear, scan_overrun (level reload).
//  Pixel stage 1: per-entry hit_i = valid && ph<=vga_h<ph+w && pv<=vga_v<pv+h.
//    Sums formed COORD_W+1 bits wide (no wrap); w or h of 0 never hits. Register hit vector and offsets.
//  Pixel stage 2: lowest index with hit wins.
//    addr = (mv+(vga_v-pv))*MEM_W + mh+(vga_h-ph), truncated to ADDR_W, registered.
//    No hit -> addr=DEFAULT_ADDR, hit=0.
//  Pipeline runs every cycle, independent of the FSM. Table changes are visible to pixels from stage 1 of the cycle after the write.
//  FSM: IDLE -(frame_start)-> SCAN; player coords latched on entry; idx=0, accumulators cleared.
//    SCAN: one entry per cycle. Box overlap uses strict inequalities: p_h<ph+w && p_h+PW>ph, and likewise vertical, all sums COORD_W+1 bits.
//    OR into per-player solid/red/blue/goal accumulators. After idx=NUM_RECTS-1 go to DONE.
//    DONE (1 cycle): p*_solid <= acc_solid.
//    DONE, hazards (TERRAIN_HAZARD_EN): p1_dead |= acc_blue1, p2_dead |= acc_red2.
//    DONE: clear |= goal1&&goal2. Then go to IDLE.
//    Scan length = NUM_RECTS+1 cycles. cfg_ready=0 in SCAN and DONE.
//    frame_start during SCAN/DONE is ignored and sets scan_overrun. frame_start in the same cycle as DONE is ignored.
//  Reset mid-scan: abort to IDLE, reset values apply immediately (async).
// CONFIGURATION
//  TERRAIN_HAZARD_EN defined: types 1/2 are lethal as above.
//  Not defined: types 1/2 behave as type 0 (counted in p*_solid); p*_dead tied 0.
//  The pixel pipeline is identical in both builds.
// TESTING
//  1 Reset low mid-scan -> addr=12900, flags 0, cfg_ready=1 same cycle; FSM IDLE after release.
//  2 Entry0 {1,0,0,230,320,10,0,220}; pixel (5,232) -> addr=(220+2)*320+5=71045, hit=1 two cycles later.
//  2b Entry0 as in 2; pixel (5,229) -> addr=12900, hit=0.
//  3 Entry0 solid at (150,230,40,10) and entry1 red at same box; pixel (150,230) -> entry0 address (priority).
//  4 Entry2 red at (150,230,40,6); p2 at (145,222); pulse frame_start -> p2_dead=1 after 9 cycles (HAZARD_EN).
//  4b Same as 4 but p1 only -> p1_dead=0.
//  4c Same as 4 without HAZARD_EN -> p2_solid=1, p2_dead=0.
//  5 Both players overlapping a goal -> clear=1 after scan; then a cfg write -> clear=0.
//  5b Repeat frame_start mid-scan -> scan_overrun=1, scan not restarted.
//  6 cfg_we during SCAN -> dropped (entry unchanged); cfg_idx=12 with NUM_RECTS=8 -> dropped.

Source files
------------

// File: rtl/terrain_compositor.sv
// Table-driven terrain layer: two-stage pixel-to-sprite-address pipeline plus a per-frame player collision scanner.
// Define TERRAIN_HAZARD_EN to make types 1/2 lethal; otherwise they count as solid and p*_dead stays 0.
module terrain_compositor #(
  parameter int unsigned NUM_RECTS    = 8,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned MEM_W        = 320,
  parameter int unsigned DEFAULT_ADDR = 12900,
  parameter int unsigned PW           = 10,
  parameter int unsigned PH           = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [6*COORD_W+2:0]   cfg_data,
  output logic                   cfg_ready,
  input  logic [COORD_W-1:0]     vga_h,
  input  logic [COORD_W-1:0]     vga_v,
  output logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  input  logic                   frame_start,
  input  logic [COORD_W-1:0]     p1_h,
  input  logic [COORD_W-1:0]     p1_v,
  input  logic [COORD_W-1:0]     p2_h,
  input  logic [COORD_W-1:0]     p2_v,
  output logic                   p1_solid,
  output logic                   p2_solid,
  output logic                   p1_dead,
  output logic                   p2_dead,
  output logic                   clear,
  output logic                   scan_overrun
);

  localparam int unsigned CW1 = COORD_W + 1;

  typedef struct packed {
    logic               valid;
    logic [1:0]         kind;
    logic [COORD_W-1:0] ph, pv, w, h, mh, mv;
  } rect_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  rect_t  rects [NUM_RECTS];
  state_t state, state_next;
  logic   wr_accept;

  assign cfg_ready = (state == IDLE);
  assign wr_accept = cfg_we && cfg_ready && (32'(cfg_idx) < NUM_RECTS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++) rects[i] <= '0;
    end else if (wr_accept) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++)
        if (cfg_idx == 4'(i)) rects[i] <= cfg_data;
    end
  end

  logic [NUM_RECTS-1:0] pix_hit, s1_hit;
  logic [CW1-1:0]       pix_row [NUM_RECTS];
  logic [CW1-1:0]       pix_col [NUM_RECTS];
  logic [CW1-1:0]       s1_row  [NUM_RECTS];
  logic [CW1-1:0]       s1_col  [NUM_RECTS];
  logic                 sel_hit;
  logic [CW1-1:0]       sel_row, sel_col;
  logic [ADDR_W-1:0]    sel_addr;

  always_comb begin
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      pix_hit[i] = rects[i].valid
                && (vga_h >= rects[i].ph) && ({1'b0, vga_h} < {1'b0, rects[i].ph} + {1'b0, rects[i].w})
                && (vga_v >= rects[i].pv) && ({1'b0, vga_v} < {1'b0, rects[i].pv} + {1'b0, rects[i].h});
      pix_col[i] = {1'b0, rects[i].mh} + {1'b0, vga_h - rects[i].ph};
      pix_row[i] = {1'b0, rects[i].mv} + {1'b0, vga_v - rects[i].pv};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hit <= '0;
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        s1_row[i] <= '0;
        s1_col[i] <= '0;
      end
    end else begin
      s1_hit <= pix_hit;
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        s1_row[i] <= pix_row[i];
        s1_col[i] <= pix_col[i];
      end
    end
  end

  // Lowest index wins: the first hit found freezes the selection.
  always_comb begin
    sel_hit = 1'b0;
    sel_row = '0;
    sel_col = '0;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      if (s1_hit[i] && !sel_hit) begin
        sel_hit = 1'b1;
        sel_row = s1_row[i];
        sel_col = s1_col[i];
      end
    end
    sel_addr = ADDR_W'(32'(sel_row) * MEM_W + 32'(sel_col));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= ADDR_W'(DEFAULT_ADDR);
      hit  <= 1'b0;
    end else begin
      addr <= sel_hit ? sel_addr : ADDR_W'(DEFAULT_ADDR);
      hit  <= sel_hit;
    end
  end

  function automatic logic overlap(input logic valid,
                                   input logic [COORD_W-1:0] rh, rv, rw, rhh, x, y);
    return valid
        && ({1'b0, x} < {1'b0, rh} + {1'b0, rw}) && ({1'b0, x} + CW1'(PW) > {1'b0, rh})
        && ({1'b0, y} < {1'b0, rv} + {1'b0, rhh}) && ({1'b0, y} + CW1'(PH) > {1'b0, rv});
  endfunction

  logic [3:0]         idx;
  logic [COORD_W-1:0] p1h_q, p1v_q, p2h_q, p2v_q;
  logic               cur_valid;
  logic [1:0]         cur_kind;
  logic [COORD_W-1:0] cur_ph, cur_pv, cur_w, cur_h;
  logic               ov1, ov2, is_solid, is_goal;
  logic               acc_solid1, acc_solid2, acc_goal1, acc_goal2;

  always_comb begin
    cur_valid = 1'b0;
    cur_kind  = '0;
    cur_ph    = '0;
    cur_pv    = '0;
    cur_w     = '0;
    cur_h     = '0;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      if (idx == 4'(i)) begin
        cur_valid = rects[i].valid;
        cur_kind  = rects[i].kind;
        cur_ph    = rects[i].ph;
        cur_pv    = rects[i].pv;
        cur_w     = rects[i].w;
        cur_h     = rects[i].h;
      end
    end
    ov1 = overlap(cur_valid, cur_ph, cur_pv, cur_w, cur_h, p1h_q, p1v_q);
    ov2 = overlap(cur_valid, cur_ph, cur_pv, cur_w, cur_h, p2h_q, p2v_q);
`ifdef TERRAIN_HAZARD_EN
    is_solid = (cur_kind == 2'd0);
`else
    is_solid = (cur_kind == 2'd0) || (cur_kind == 2'd1) || (cur_kind == 2'd2);
`endif
    is_goal = (cur_kind == 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = SCAN;
      SCAN:    if (idx == 4'(NUM_RECTS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx          <= '0;
      p1h_q        <= '0;
      p1v_q        <= '0;
      p2h_q        <= '0;
      p2v_q        <= '0;
      acc_solid1   <= 1'b0;
      acc_solid2   <= 1'b0;
      acc_goal1    <= 1'b0;
      acc_goal2    <= 1'b0;
      p1_solid     <= 1'b0;
      p2_solid     <= 1'b0;
      clear        <= 1'b0;
      scan_overrun <= 1'b0;
    end else begin
      if (wr_accept) begin
        clear        <= 1'b0;
        scan_overrun <= 1'b0;
      end
      case (state)
        IDLE: if (frame_start) begin
          idx        <= '0;
          p1h_q      <= p1_h;
          p1v_q      <= p1_v;
          p2h_q      <= p2_h;
          p2v_q      <= p2_v;
          acc_solid1 <= 1'b0;
          acc_solid2 <= 1'b0;
          acc_goal1  <= 1'b0;
          acc_goal2  <= 1'b0;
        end
        SCAN: begin
          idx        <= idx + 4'd1;
          acc_solid1 <= acc_solid1 | (ov1 & is_solid);
          acc_solid2 <= acc_solid2 | (ov2 & is_solid);
          acc_goal1  <= acc_goal1  | (ov1 & is_goal);
          acc_goal2  <= acc_goal2  | (ov2 & is_goal);
          if (frame_start) scan_overrun <= 1'b1;
        end
        DONE: begin
          p1_solid <= acc_solid1;
          p2_solid <= acc_solid2;
          clear    <= clear | (acc_goal1 & acc_goal2);
          if (frame_start) scan_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TERRAIN_HAZARD_EN
  logic acc_blue1, acc_red2, p1_dead_q, p2_dead_q;

  // Red hazards kill player 2, blue hazards kill player 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_blue1 <= 1'b0;
      acc_red2  <= 1'b0;
      p1_dead_q <= 1'b0;
      p2_dead_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        p1_dead_q <= 1'b0;
        p2_dead_q <= 1'b0;
      end
      case (state)
        IDLE: if (frame_start) begin
          acc_blue1 <= 1'b0;
          acc_red2  <= 1'b0;
        end
        SCAN: begin
          acc_blue1 <= acc_blue1 | (ov1 & (cur_kind == 2'd2));
          acc_red2  <= acc_red2  | (ov2 & (cur_kind == 2'd1));
        end
        DONE: begin
          p1_dead_q <= p1_dead_q | acc_blue1;
          p2_dead_q <= p2_dead_q | acc_red2;
        end
        default: ;
      endcase
    end
  end

  assign p1_dead = p1_dead_q;
  assign p2_dead = p2_dead_q;
`else
  assign p1_dead = 1'b0;
  assign p2_dead = 1'b0;
`endif

endmodule

// File: tb/tb_terrain_compositor.sv
// Directed self-checking bench for terrain_compositor (pixel pipeline, collision scan, config gating, reset).
module tb_terrain_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [62:0] cfg_data;
  logic        cfg_ready;
  logic [9:0]  vga_h, vga_v;
  logic [16:0] addr;
  logic        hit;
  logic        frame_start;
  logic [9:0]  p1_h, p1_v, p2_h, p2_v;
  logic        p1_solid, p2_solid, p1_dead, p2_dead, clear, scan_overrun;

  int checks = 0;
  int errors = 0;

  terrain_compositor #(.NUM_RECTS(8), .COORD_W(10), .ADDR_W(17), .MEM_W(320),
                       .DEFAULT_ADDR(12900), .PW(10), .PH(10)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .vga_h(vga_h), .vga_v(vga_v), .addr(addr), .hit(hit),
    .frame_start(frame_start), .p1_h(p1_h), .p1_v(p1_v), .p2_h(p2_h), .p2_v(p2_v),
    .p1_solid(p1_solid), .p2_solid(p2_solid), .p1_dead(p1_dead), .p2_dead(p2_dead),
    .clear(clear), .scan_overrun(scan_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [62:0] mk(input logic v, input logic [1:0] t,
                                     input logic [9:0] ph, pv, w, h, mh, mv);
    return {v, t, ph, pv, w, h, mh, mv};
  endfunction

  task automatic wr(input logic [3:0] i, input logic [62:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) wr(4'(i), '0);
  endtask

  task automatic pixel(input logic [9:0] h, input logic [9:0] v);
    vga_h = h; vga_v = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic players(input logic [9:0] a, b, c, d);
    p1_h = a; p1_v = b; p2_h = c; p2_v = d;
  endtask

  task automatic scan();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic chk_pix(input string name, input logic [16:0] ea, input logic eh);
    checks++;
    if (addr !== ea || hit !== eh) begin
      errors++;
      $display("FAIL %s: got addr=%0d hit=%0b, expected addr=%0d hit=%0b", name, addr, hit, ea, eh);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (addr !== 17'd12900 || hit !== 1'b0 || cfg_ready !== 1'b1 ||
        {p1_solid, p2_solid, p1_dead, p2_dead, clear, scan_overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%0d hit=%0b ready=%0b flags=%b, expected 12900 0 1 000000",
               addr, hit, cfg_ready, {p1_solid, p2_solid, p1_dead, p2_dead, clear, scan_overrun});
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pixel();
    wr(0, mk(1, 0, 0, 230, 320, 10, 0, 220));
    vga_h = 5; vga_v = 232;
    @(posedge clk); #1;
    chk_pix("pix_latency1", 17'd12900, 1'b0);
    @(posedge clk); #1;
    chk_pix("pix_basic", 17'd71045, 1'b1);
    pixel(5, 229);   chk_pix("pix_above", 17'd12900, 1'b0);
    pixel(319, 239); chk_pix("pix_corner", 17'd73599, 1'b1);
    pixel(320, 232); chk_pix("pix_right_edge", 17'd12900, 1'b0);
    pixel(5, 240);   chk_pix("pix_bottom_edge", 17'd12900, 1'b0);
  endtask

  task automatic test_priority();
    wr(0, mk(1, 0, 150, 230, 40, 10, 10, 20));
    wr(1, mk(1, 1, 150, 230, 40, 10, 100, 200));
    pixel(150, 230); chk_pix("prio_entry0", 17'd6410, 1'b1);
    wr(0, mk(0, 0, 150, 230, 40, 10, 10, 20));
    pixel(150, 230); chk_pix("prio_entry1", 17'd64100, 1'b1);
    wr(0, mk(1, 0, 150, 230, 0, 10, 10, 20));
    pixel(150, 230); chk_pix("prio_zero_width", 17'd64100, 1'b1);
  endtask

  task automatic test_hazard();
    clear_table();
    wr(2, mk(1, 1, 150, 230, 40, 6, 0, 0));
    players(0, 0, 145, 222);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (cfg_ready !== 1'b0 || p2_dead !== 1'b0 || p2_solid !== 1'b0) begin
      errors++;
      $display("FAIL scan_in_done: ready=%0b p2_dead=%0b p2_solid=%0b, expected 0 0 0", cfg_ready, p2_dead, p2_solid);
    end
    @(posedge clk); #1;
`ifdef TERRAIN_HAZARD_EN
    checks++;
    if (p2_dead !== 1'b1 || p2_solid !== 1'b0 || p1_dead !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL red_kills_p2: p2_dead=%0b p2_solid=%0b p1_dead=%0b ready=%0b, expected 1 0 0 1",
               p2_dead, p2_solid, p1_dead, cfg_ready);
    end
`else
    checks++;
    if (p2_solid !== 1'b1 || p2_dead !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL red_as_solid: p2_solid=%0b p2_dead=%0b ready=%0b, expected 1 0 1", p2_solid, p2_dead, cfg_ready);
    end
`endif
    wr(2, mk(1, 1, 150, 230, 40, 6, 0, 0));
    players(145, 222, 0, 0);
    scan();
`ifdef TERRAIN_HAZARD_EN
    checks++;
    if (p1_dead !== 1'b0 || p2_dead !== 1'b0 || p1_solid !== 1'b0) begin
      errors++;
      $display("FAIL red_spares_p1: p1_dead=%0b p2_dead=%0b p1_solid=%0b, expected 0 0 0", p1_dead, p2_dead, p1_solid);
    end
    wr(2, mk(1, 2, 150, 230, 40, 6, 0, 0));
    scan();
    checks++;
    if (p1_dead !== 1'b1 || p2_dead !== 1'b0) begin
      errors++;
      $display("FAIL blue_kills_p1: p1_dead=%0b p2_dead=%0b, expected 1 0", p1_dead, p2_dead);
    end
`else
    checks++;
    if (p1_solid !== 1'b1 || p1_dead !== 1'b0) begin
      errors++;
      $display("FAIL red_as_solid_p1: p1_solid=%0b p1_dead=%0b, expected 1 0", p1_solid, p1_dead);
    end
`endif
    wr(2, mk(1, 0, 150, 230, 40, 6, 0, 0));
    players(0, 0, 145, 222);
    scan();
    checks++;
    if (p2_solid !== 1'b1 || p1_solid !== 1'b0 || p1_dead !== 1'b0) begin
      errors++;
      $display("FAIL solid_p2: p2_solid=%0b p1_solid=%0b p1_dead=%0b, expected 1 0 0", p2_solid, p1_solid, p1_dead);
    end
    players(0, 0, 140, 222);
    scan();
    checks++;
    if (p2_solid !== 1'b0) begin
      errors++;
      $display("FAIL strict_edge_touch: p2_solid=%0b, expected 0", p2_solid);
    end
    players(0, 0, 141, 222);
    scan();
    checks++;
    if (p2_solid !== 1'b1) begin
      errors++;
      $display("FAIL strict_edge_overlap: p2_solid=%0b, expected 1", p2_solid);
    end
  endtask

  task automatic test_goal();
    clear_table();
    wr(3, mk(1, 3, 50, 50, 20, 20, 0, 0));
    players(45, 45, 100, 100);
    scan();
    checks++;
    if (clear !== 1'b0) begin
      errors++;
      $display("FAIL goal_one_player: clear=%0b, expected 0", clear);
    end
    players(45, 45, 60, 60);
    scan();
    checks++;
    if (clear !== 1'b1 || p1_solid !== 1'b0 || p2_solid !== 1'b0) begin
      errors++;
      $display("FAIL goal_both: clear=%0b p1_solid=%0b p2_solid=%0b, expected 1 0 0", clear, p1_solid, p2_solid);
    end
    players(45, 45, 100, 100);
    scan();
    checks++;
    if (clear !== 1'b1) begin
      errors++;
      $display("FAIL goal_sticky: clear=%0b, expected 1", clear);
    end
    wr(3, mk(1, 3, 50, 50, 20, 20, 0, 0));
    checks++;
    if (clear !== 1'b0) begin
      errors++;
      $display("FAIL goal_cleared_by_write: clear=%0b, expected 0", clear);
    end
  endtask

  task automatic test_overrun();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    checks++;
    if (scan_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: scan_overrun=%0b, expected 1", scan_overrun);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL overrun_done_state: ready=%0b, expected 0", cfg_ready);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun_not_restarted: ready=%0b, expected 1", cfg_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_start_ignored: ready=%0b, expected 1", cfg_ready);
    end
    wr(5, '0);
    checks++;
    if (scan_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_cleared: scan_overrun=%0b, expected 0", scan_overrun);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (8) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    checks++;
    if (scan_overrun !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun_in_done: scan_overrun=%0b ready=%0b, expected 1 1", scan_overrun, cfg_ready);
    end
  endtask

  task automatic test_cfg_drop();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    cfg_we = 1'b1; cfg_idx = 0; cfg_data = mk(1, 0, 500, 500, 10, 10, 0, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    pixel(500, 500); chk_pix("drop_during_scan", 17'd12900, 1'b0);
    wr(12, mk(1, 0, 500, 500, 10, 10, 0, 0));
    pixel(500, 500); chk_pix("drop_idx_range", 17'd12900, 1'b0);
    checks++;
    if (scan_overrun !== 1'b1) begin
      errors++;
      $display("FAIL dropped_keeps_flags: scan_overrun=%0b, expected 1", scan_overrun);
    end
    wr(4, mk(1, 0, 500, 500, 10, 10, 0, 0));
    pixel(500, 500); chk_pix("accept_idx4", 17'd0, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    wr(0, mk(1, 0, 0, 0, 100, 100, 5, 5));
    wr(1, mk(1, 3, 0, 0, 100, 100, 0, 0));
    players(10, 10, 20, 20);
    scan();
    pixel(1, 1);
    checks++;
    if (clear !== 1'b1 || p1_solid !== 1'b1 || addr !== 17'd1926) begin
      errors++;
      $display("FAIL pre_reset_state: clear=%0b p1_solid=%0b addr=%0d, expected 1 1 1926", clear, p1_solid, addr);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (addr !== 17'd12900 || hit !== 1'b0 || cfg_ready !== 1'b1 ||
        {p1_solid, p2_solid, p1_dead, p2_dead, clear, scan_overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: addr=%0d hit=%0b ready=%0b flags=%b, expected 12900 0 1 000000",
               addr, hit, cfg_ready, {p1_solid, p2_solid, p1_dead, p2_dead, clear, scan_overrun});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_pix("post_reset_table_empty", 17'd12900, 1'b0);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%0b, expected 1", cfg_ready);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_scan_starts: ready=%0b, expected 0", cfg_ready);
    end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    vga_h = '0; vga_v = '0; frame_start = 1'b0;
    players(0, 0, 0, 0);
    test_reset();
    test_pixel();
    test_priority();
    test_hazard();
    test_goal();
    test_overrun();
    test_cfg_drop();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
